// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode encodings and the
// fetch-queue entry format.
package cpu_pkg;

   localparam int INSTR_W    = 12;
   localparam int ROM_ADDR_W = 8;

   localparam int TYPE_BIT = 11;
   localparam int OP_MSB   = 10;
   localparam int OP_LSB   = 8;
   localparam int IMM_MSB  = 7;
   localparam int IMM_LSB  = 0;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_NOT = 3'd7
   } opcode_e;

   typedef struct packed {
      logic [ROM_ADDR_W-1:0] addr;
      logic [INSTR_W-1:0]    instr;
   } fifo_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Fetch-queue storage: circular buffer with head/tail pointers, occupancy
// count and a synchronous clear that takes priority over push/pop.
module ifq_fifo import cpu_pkg::*; #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fifo_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  entry_t                 wr_entry,
   output entry_t                 head_entry,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [PTR_W:0]     count_q;

   // Storage is reset too so the head word reads as zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (clear) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[tail] <= wr_entry;
            tail      <= tail + PTR_W'(1);
         end
         if (pop) head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_entry = mem[head];
   assign count      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch pc, pushes ROM words into ifq_fifo
// and arbitrates flush against push. IFQ_PC_WRAP_EN lets pc wrap forever;
// otherwise fetch halts after the last ROM address and end_of_rom is raised.
module instr_fetch_queue #(
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter int ADDR_W  = cpu_pkg::ROM_ADDR_W,
   parameter int DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [INSTR_W-1:0]     rom_data,
   output logic [INSTR_W-1:0]     instr,
   output logic [ADDR_W-1:0]      instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   flush,
   input  logic [ADDR_W-1:0]      flush_pc,
   output logic [$clog2(DEPTH):0] count,
   output logic                   end_of_rom
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t            wr_entry;
   entry_t            head_entry;
   logic [ADDR_W-1:0] pc;
   logic              push;
   logic              pop;

   // Push eligibility looks only at registered count, so a pop from a full
   // queue frees the slot for the following cycle.
`ifdef IFQ_PC_WRAP_EN
   assign push       = !flush && (count < CNT_W'(DEPTH));
   assign end_of_rom = 1'b0;
`else
   logic halted;

   assign push       = !flush && (count < CNT_W'(DEPTH)) && !halted;
   assign end_of_rom = halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      halted <= 1'b0;
      else if (flush)               halted <= 1'b0;
      else if (push && (pc == '1))  halted <= 1'b1;
   end
`endif

   assign pop         = instr_valid && instr_ready;
   assign instr_valid = (count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        pc <= '0;
      else if (flush) pc <= flush_pc;
      else if (push)  pc <= pc + ADDR_W'(1);
   end

   assign rom_addr       = pc;
   assign wr_entry.addr  = pc;
   assign wr_entry.instr = rom_data;

   ifq_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .push       (push),
      .pop        (pop),
      .wr_entry   (wr_entry),
      .head_entry (head_entry),
      .count      (count)
   );

   assign instr    = head_entry.instr;
   assign instr_pc = head_entry.addr;

endmodule
